// File: rtl/out_display_driver.sv
// Output-register display driver: converts the latched binary value to BCD with a
// sequential double-dabble engine and multiplexes three decimal digits onto a 4-digit display.
module out_display_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] out_val,
  input  logic                  load,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [3:0]            digit_an
);

  // Enough BCD nibbles for the full input range, never fewer than the three displayed.
  localparam int NDIG_RAW = (DATA_WIDTH * 31) / 100 + 1;
  localparam int NDIG     = (NDIG_RAW < 3) ? 3 : NDIG_RAW;
  localparam int BCD_W    = 4 * NDIG;
  localparam int CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam int PS_W     = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]      step_q, step_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_val_q, pend_val_d;
  logic [11:0]           disp_q, disp_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [1:0]            dig_q, dig_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            an_q, an_d;

  logic [BCD_W-1:0]            bcd_adj;
  logic [BCD_W+DATA_WIDTH-1:0] dd_shifted;
  logic                        start_conv;
  logic [DATA_WIDTH-1:0]       start_val;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_add3
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? bcd_q[gi*4 +: 4] + 4'd3
                                                             : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign dd_shifted = {bcd_adj, shift_q} << 1;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (step_q == STEP_LAST) state_d = COMMIT;
      COMMIT:  state_d = (pend_valid_q || load) ? CONVERT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // A load arriving in the COMMIT cycle is newer than the pending slot, so it wins.
  always_comb begin
    start_conv = 1'b0;
    start_val  = out_val;
    if (state_q == IDLE && load) begin
      start_conv = 1'b1;
    end else if (state_q == COMMIT && (load || pend_valid_q)) begin
      start_conv = 1'b1;
      start_val  = load ? out_val : pend_val_q;
    end
  end

  always_comb begin
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    step_d       = step_q;
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    disp_d       = disp_q;

    if (state_q == CONVERT) begin
      {bcd_d, shift_d} = dd_shifted;
      step_d           = step_q + CNT_W'(1);
      if (load) begin
        pend_valid_d = 1'b1;
        pend_val_d   = out_val;
      end
    end

    if (state_q == COMMIT) begin
      disp_d       = bcd_q[11:0];
      pend_valid_d = 1'b0;
    end

    if (start_conv) begin
      shift_d = start_val;
      bcd_d   = '0;
      step_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q      <= '0;
      bcd_q        <= '0;
      step_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      disp_q       <= '0;
    end else begin
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      step_q       <= step_d;
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      disp_q       <= disp_d;
    end
  end

  // Segment data is derived from next-cycle latch and index so seg and digit_an move together.
  always_comb begin
    logic [3:0] hund, tens, ones;
    hund = disp_d[11:8];
    tens = disp_d[7:4];
    ones = disp_d[3:0];

    presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
    dig_d   = (presc_q == PS_LAST) ? dig_q + 2'd1 : dig_q;
    an_d    = ~(4'b0001 << dig_d);

    seg_d = 7'b0000000;
    case (dig_d)
      2'd0: seg_d = seg_decode(ones);
      2'd1: seg_d = (hund == 4'd0 && tens == 4'd0) ? 7'b0000000 : seg_decode(tens);
      2'd2: seg_d = (hund == 4'd0) ? 7'b0000000 : seg_decode(hund);
      default: seg_d = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      dig_q   <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b0111111;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg      = seg_q;
  assign digit_an = an_q;

endmodule

// File: tb/tb_out_display_driver.sv
// Directed bench for out_display_driver: table of values with hand-computed segment
// patterns, plus sequences for pending loads, scan timing and reset mid-conversion.
module tb_out_display_driver;

  localparam int DW   = 8;
  localparam int SCAN = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] out_val;
  logic          load;
  logic          busy;
  logic [6:0]    seg;
  logic [3:0]    digit_an;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] cur2, cur1, cur0;

  typedef struct {
    logic [7:0] val;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
  } vec_t;

  vec_t vecs[8];

  out_display_driver #(.DATA_WIDTH(DW), .SCAN_DIV(SCAN)) dut (
    .clk(clk),
    .reset(reset),
    .out_val(out_val),
    .load(load),
    .busy(busy),
    .seg(seg),
    .digit_an(digit_an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int an_idx(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [6:0] pick(input int idx, input logic [6:0] e2, e1, e0);
    case (idx)
      0: return e0;
      1: return e1;
      2: return e2;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_seg(input string name, input logic [6:0] e2, e1, e0);
    int idx;
    idx = an_idx(digit_an);
    if (idx < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: digit_an %b not one-hot-low", name, digit_an);
    end else begin
      check(name, {25'd0, seg}, {25'd0, pick(idx, e2, e1, e0)});
    end
  endtask

  task automatic check_display(input string name, input logic [6:0] e2, e1, e0);
    bit seen[4];
    int idx;
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    for (int n = 0; n < 4 * SCAN + 4; n++) begin
      @(posedge clk); #1;
      idx = an_idx(digit_an);
      if (idx < 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_onehot: digit_an %b", name, digit_an);
      end else if (!seen[idx]) begin
        seen[idx] = 1'b1;
        check($sformatf("%s_d%0d", name, idx), {25'd0, seg}, {25'd0, pick(idx, e2, e1, e0)});
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (!seen[k]) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_scan: digit %0d never enabled, got none expected enabled", name, k);
      end
    end
  endtask

  // Called just after a rising edge; the load is sampled at the next edge (edge k).
  task automatic run_vector(input int i, input logic [7:0] v, input logic [6:0] e2, e1, e0);
    out_val = v;
    load    = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check($sformatf("v%0d_busy0", i), {31'd0, busy}, 32'd1);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      check($sformatf("v%0d_busy%0d", i, j), {31'd0, busy}, 32'd1);
      if (j == 8) check_seg($sformatf("v%0d_old_k8", i), cur2, cur1, cur0);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d_busy9", i), {31'd0, busy}, 32'd0);
    check_seg($sformatf("v%0d_new_k9", i), e2, e1, e0);
    cur2 = e2; cur1 = e1; cur0 = e0;
    check_display($sformatf("v%0d_disp", i), e2, e1, e0);
  endtask

  initial begin
    vecs[0] = '{8'h09, 7'b0000000, 7'b0000000, 7'b1101111};
    vecs[1] = '{8'hFF, 7'b1011011, 7'b1101101, 7'b1101101};
    vecs[2] = '{8'h64, 7'b0000110, 7'b0111111, 7'b0111111};
    vecs[3] = '{8'h00, 7'b0000000, 7'b0000000, 7'b0111111};
    vecs[4] = '{8'h7B, 7'b0000110, 7'b1011011, 7'b1001111};
    vecs[5] = '{8'h2D, 7'b0000000, 7'b1100110, 7'b1101101};
    vecs[6] = '{8'hC8, 7'b1011011, 7'b0111111, 7'b0111111};
    vecs[7] = '{8'h57, 7'b0000000, 7'b1111111, 7'b0000111};

    reset = 1'b1; load = 1'b0; out_val = '0;
    cur2 = 7'b0000000; cur1 = 7'b0000000; cur0 = 7'b0111111;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_an", {28'd0, digit_an}, {28'd0, 4'b1110});
    check("rst_seg", {25'd0, seg}, {25'd0, 7'b0111111});
    @(posedge clk); #1;
    reset = 1'b0;

    // First vector loads on the very first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      run_vector(i, vecs[i].val, vecs[i].s2, vecs[i].s1, vecs[i].s0);
    end

    // Loads during busy: 0x2A is overwritten by 0x03 before it can start.
    for (int t = 0; t <= 18; t++) begin
      load    = (t == 0 || t == 2 || t == 5);
      out_val = (t == 0) ? 8'h0A : (t == 2) ? 8'h2A : 8'h03;
      @(posedge clk); #1;
      load = 1'b0;
      check($sformatf("pend_busy_t%0d", t), {31'd0, busy}, {31'd0, (t < 18)});
      if (t < 9)       check_seg($sformatf("pend_seg_t%0d", t), cur2, cur1, cur0);
      else if (t < 18) check_seg($sformatf("pend_seg_t%0d", t), 7'b0000000, 7'b0000110, 7'b0111111);
      else             check_seg($sformatf("pend_seg_t%0d", t), 7'b0000000, 7'b0000000, 7'b1001111);
    end
    cur2 = 7'b0000000; cur1 = 7'b0000000; cur0 = 7'b1001111;
    check_display("pend_disp", cur2, cur1, cur0);

    // Scan order and dwell time.
    begin
      logic [3:0] prev_an;
      logic [3:0] pats[4];
      bit         found;
      pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
      found = 1'b0;
      prev_an = digit_an;
      for (int n = 0; n < 4 * SCAN * 2 && !found; n++) begin
        @(posedge clk); #1;
        if (prev_an == 4'b0111 && digit_an == 4'b1110) found = 1'b1;
        prev_an = digit_an;
      end
      if (!found) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scan_sync: got no 0111->1110 transition expected one");
      end else begin
        for (int n = 0; n < 5 * SCAN; n++) begin
          if (n > 0) begin @(posedge clk); #1; end
          check($sformatf("scan_n%0d", n), {28'd0, digit_an}, {28'd0, pats[(n / SCAN) % 4]});
        end
      end
    end

    // Reset in the middle of a 0xC8 conversion.
    out_val = 8'hC8;
    load    = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_an", {28'd0, digit_an}, {28'd0, 4'b1110});
    check("arst_seg", {25'd0, seg}, {25'd0, 7'b0111111});
    @(posedge clk); @(posedge clk); #1;
    check("arst_hold_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("arst_post_busy", {31'd0, busy}, 32'd0);
    cur2 = 7'b0000000; cur1 = 7'b0000000; cur0 = 7'b0111111;
    check_display("arst_disp", cur2, cur1, cur0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/out_display_driver.md
OUT_DISPLAY_DRIVER -- requirements
Module: out_display_driver

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the output-register value consumed by this block.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles each digit stays enabled; legal range is 2 or more.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port out_val  input  DATA_WIDTH  unsigned value held by the CPU output register.
REQ-006 Port load  input  1  one-cycle strobe; asserted in the cycle the output register latches a new value.
REQ-007 Port busy  output  1  high while a binary-to-BCD conversion is in progress.
REQ-008 Port seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
REQ-009 Port digit_an  output  4  digit enables, active-low; bit 0 is the ones digit.

Function
REQ-010 The block SHALL implement FSM states IDLE, CONVERT and COMMIT.
REQ-011 In IDLE, a rising edge with load=1 SHALL capture out_val into a shift register, clear the BCD scratch register, clear the step counter, and enter CONVERT.
REQ-012 CONVERT SHALL run the shift-add-3 (double-dabble) algorithm with exactly one shift per cycle for DATA_WIDTH cycles.
REQ-013 In each CONVERT cycle, any BCD nibble of 5 or more SHALL have 3 added before the shift.
REQ-014 After the DATA_WIDTH-th shift the FSM SHALL enter COMMIT.
REQ-015 COMMIT SHALL copy the hundreds, tens and ones nibbles into the display latch and return to IDLE in one cycle.
REQ-016 busy SHALL be 1 in CONVERT and COMMIT, and 0 in IDLE.
REQ-017 With load sampled at edge k, the display latch SHALL change at edge k+DATA_WIDTH+1, which is edge k+9 for the default width.
REQ-018 load=1 while busy=1 SHALL record out_val in a single pending slot; a later load while busy SHALL overwrite that slot, so the last value wins.
REQ-019 On leaving COMMIT with the pending slot valid, the FSM SHALL start conversion of the pending value immediately, without passing through IDLE, and SHALL clear the slot.
REQ-020 The display latch SHALL never hold a partially converted value.
REQ-021 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap the digit index (0..3) SHALL advance, wrapping from 3 to 0.
REQ-022 Exactly one digit_an bit SHALL be low at any time.
REQ-023 Digit 0 SHALL always show the ones digit, including 0.
REQ-024 Digit 1 SHALL show tens, blanked (seg=0) when hundreds and tens are both 0.
REQ-025 Digit 2 SHALL show hundreds, blanked when hundreds is 0.
REQ-026 Digit 3 SHALL always be blanked.
REQ-027 Decimal segment patterns ({g..a}): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-028 seg and digit_an SHALL be registered outputs and SHALL change on the same edge.

Reset
REQ-029 Reset SHALL force the following immediately and without a clock edge:
- FSM to IDLE, busy=0, pending slot cleared;
- display latch to 0,0,0;
- prescaler=0, digit index=0;
- digit_an=4'b1110 and seg=0111111.
REQ-030 Reset asserted during CONVERT SHALL abandon the conversion; the display SHALL show 0 after release.
REQ-031 After reset release, the first load SHALL be accepted on the first rising edge.

Verification
REQ-032 Reset, load out_val=0x09 -> busy high 9 cycles; then digit0 seg=1101111, digit1 and digit2 seg=0000000, digit3 blank.
REQ-033 load out_val=0xFF -> latch 2,5,5; digit2=1011011, digit1=1101101, digit0=1101101.
REQ-034 load out_val=0x64 -> latch 1,0,0; digits 2,1,0 = 0000110, 0111111, 0111111, so the middle zero is not blanked.
REQ-035 load 0x0A, then load 0x2A and 0x03 during busy -> latch shows 10, then 3; 0x2A is never displayed; busy stays high continuously for 18 cycles.
REQ-036 SCAN_DIV=4 -> digit_an sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles.
REQ-037 Reset pulse 4 cycles after a load of 0xC8 -> busy=0 and digit_an=1110/seg=0111111 immediately; display still 0 ten cycles after release.
